// File: rtl/shift_pipe_rr_arbiter_if.sv
// Requester/output bundle for shift_pipe_rr_arbiter.
// master = requesters and consumer side, slave = the arbiter itself.
interface shift_pipe_rr_arbiter_if #(
    parameter int n_req = 4,
    parameter int width = 8
);
    localparam int id_w = $clog2(n_req);

    logic [n_req-1:0]       req_vld;
    logic [n_req*width-1:0] req_data;
    logic [n_req-1:0]       req_rdy;
    logic                   out_vld;
    logic [width-1:0]       out_data;
    logic [id_w-1:0]        out_id;

    modport master (
        output req_vld, req_data,
        input  req_rdy, out_vld, out_data, out_id
    );

    modport slave (
        input  req_vld, req_data,
        output req_rdy, out_vld, out_data, out_id
    );
endinterface

// File: rtl/shift_pipe_rr_arbiter.sv
// Round-robin arbiter feeding a fixed-latency, non-stalling shift pipeline with an in-flight cap.
// Define SHIFT_PIPE_ARB_PRIO0_EN to give requester 0 absolute priority over the rotation.
module shift_pipe_rr_arbiter #(
    parameter int n_req        = 4,
    parameter int width        = 8,
    parameter int depth        = 8,
    parameter int max_inflight = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shift_pipe_rr_arbiter_if.slave bus
);
    localparam int id_w  = $clog2(n_req);
    localparam int cnt_w = $clog2(depth + 1);
    localparam logic [cnt_w-1:0] max_c = cnt_w'(max_inflight);

    typedef logic [id_w-1:0] id_t;

    id_t              ptr_q;
    logic [cnt_w-1:0] cnt_q;
    logic [depth-1:0] stg_vld;
    id_t              stg_id   [depth];
    logic [width-1:0] stg_data [depth];

    logic             allow;
    logic             gnt_any;
    id_t              gnt_id;
    logic [n_req-1:0] gnt_oh;
    logic             last_vld;

    assign last_vld = stg_vld[depth-1];

    // A retiring transfer frees its slot in the same cycle, so a full pipe can still accept one.
    assign allow = (cnt_q < max_c) || last_vld;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < n_req; k++) begin
            int idx;
            idx = (int'(ptr_q) + k) % n_req;
            if (!gnt_any && bus.req_vld[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = id_t'(idx);
            end
        end
`ifdef SHIFT_PIPE_ARB_PRIO0_EN
        if (bus.req_vld[0]) begin
            gnt_any = 1'b1;
            gnt_id  = '0;
        end
`endif
        if (!allow || !rst_n) begin
            gnt_any = 1'b0;
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_any) begin
            gnt_oh[gnt_id] = 1'b1;
        end
    end

    assign bus.req_rdy = gnt_oh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            stg_vld <= '0;
            for (int i = 0; i < depth; i++) begin
                stg_id[i]   <= '0;
                stg_data[i] <= '0;
            end
        end else begin
            if (gnt_any) begin
                ptr_q <= (gnt_id == id_t'(n_req - 1)) ? '0 : gnt_id + 1'b1;
            end

            if (gnt_any && !last_vld) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!gnt_any && last_vld) begin
                cnt_q <= cnt_q - 1'b1;
            end

            stg_vld <= {stg_vld[depth-2:0], gnt_any};
            // Bubbles keep stage-0 id/data so idle stages do not toggle.
            if (gnt_any) begin
                stg_id[0]   <= gnt_id;
                stg_data[0] <= bus.req_data[gnt_id*width +: width];
            end
            for (int i = 1; i < depth; i++) begin
                stg_id[i]   <= stg_id[i-1];
                stg_data[i] <= stg_data[i-1];
            end
        end
    end

    assign bus.out_vld  = last_vld;
    assign bus.out_data = stg_data[depth-1];
    assign bus.out_id   = stg_id[depth-1];
endmodule

// File: tb/tb_shift_pipe_rr_arbiter.sv
// Scoreboard bench for shift_pipe_rr_arbiter: main instance (max_inflight=8) plus a capped
// instance (max_inflight=3); expected grants come from a reference arbitration model.
module tb_shift_pipe_rr_arbiter;
    localparam int DEPTH = 8;

    typedef struct {
        int         due;
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    exp_t sbq [2][$];
    int   mp [2];
    int   mc [2];
    bit   post [2];

    always #5 clk = ~clk;

    shift_pipe_rr_arbiter_if #(.n_req(4), .width(8)) ifc ();
    shift_pipe_rr_arbiter_if #(.n_req(4), .width(8)) ifc3 ();

    shift_pipe_rr_arbiter #(.n_req(4), .width(8), .depth(DEPTH), .max_inflight(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    shift_pipe_rr_arbiter #(.n_req(4), .width(8), .depth(DEPTH), .max_inflight(3)) u_dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc3.slave)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_grant(input logic [3:0] v, input int p, input int c,
                                             input bit ov, input int maxi);
        logic [3:0] r;
        r = '0;
        if (c >= maxi && !ov) return r;
`ifdef SHIFT_PIPE_ARB_PRIO0_EN
        if (v[0]) begin
            r[0] = 1'b1;
            return r;
        end
`endif
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (p + k) % 4;
            if (v[i]) begin
                r[i] = 1'b1;
                return r;
            end
        end
        return r;
    endfunction

    task automatic mon(input int u, input logic [3:0] vld, input logic [3:0] rdy, input logic ov,
                       input logic [1:0] oid, input logic [7:0] od, input int cnt, input int ptr,
                       input logic [31:0] dbus, input int maxi);
        bit         eov;
        exp_t       e;
        logic [3:0] g;
        if (!rst_n) begin
            check_val($sformatf("u%0d_rst_rdy", u), rdy, 0);
            check_val($sformatf("u%0d_rst_out_vld", u), ov, 0);
            check_val($sformatf("u%0d_rst_out_data", u), od, 0);
            check_val($sformatf("u%0d_rst_out_id", u), oid, 0);
            sbq[u].delete();
            mp[u]   = 0;
            mc[u]   = 0;
            post[u] = 1'b1;
            return;
        end
        check_val($sformatf("u%0d_cnt", u), cnt, mc[u]);
        check_val($sformatf("u%0d_ptr", u), ptr, mp[u]);
        eov = (sbq[u].size() > 0) && (sbq[u][0].due == cyc);
        check_val($sformatf("u%0d_out_vld", u), ov, eov);
        if (eov) begin
            e = sbq[u].pop_front();
            check_val($sformatf("u%0d_out_id", u), oid, e.id);
            check_val($sformatf("u%0d_out_data", u), od, e.data);
        end
        if (post[u]) begin
            check_val($sformatf("u%0d_post_out_data", u), od, 0);
            check_val($sformatf("u%0d_post_out_id", u), oid, 0);
            post[u] = 1'b0;
        end
        g = exp_grant(vld, mp[u], mc[u], eov, maxi);
        check_val($sformatf("u%0d_req_rdy", u), rdy, g);
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                sbq[u].push_back('{due: cyc + DEPTH, id: 2'(i), data: dbus[i*8 +: 8]});
                mp[u] = (i + 1) % 4;
            end
        end
        mc[u] = mc[u] + ((g != 0) ? 1 : 0) - (eov ? 1 : 0);
    endtask

    always @(negedge clk) begin
        mon(0, ifc.req_vld, ifc.req_rdy, ifc.out_vld, ifc.out_id, ifc.out_data,
            int'(u_dut.cnt_q), int'(u_dut.ptr_q), ifc.req_data, 8);
        mon(1, ifc3.req_vld, ifc3.req_rdy, ifc3.out_vld, ifc3.out_id, ifc3.out_data,
            int'(u_dut3.cnt_q), int'(u_dut3.ptr_q), ifc3.req_data, 3);
        cyc++;
    end

    task automatic drive(input logic [3:0] v, input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            ifc.req_vld = v;
        end
    endtask

    initial begin
        ifc3.req_vld  = '0;
        ifc3.req_data = 32'h3332_3130;
        @(posedge rst_n);
        @(posedge clk);
        #1;
        ifc3.req_vld = 4'hF;
        repeat (40) @(posedge clk);
        #1;
        ifc3.req_vld = '0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ifc.req_vld  = '0;
        ifc.req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        ifc.req_data = 32'hA3A2_A1A0;
        drive(4'hF, 12);
        drive(4'h0, 12);

        ifc.req_data[23:16] = 8'h5C;
        drive(4'b0100, 1);
        drive(4'h0, 12);
        check_val("p_after_single", 32'(u_dut.ptr_q), 3);

        drive(4'b0011, 2);
        drive(4'h0, 12);

        drive(4'hF, 8);
        drive(4'h0, 12);

        repeat (60) begin
            @(posedge clk);
            #1;
            ifc.req_data = $urandom;
            ifc.req_vld  = 4'($urandom_range(0, 15));
        end
        drive(4'h0, 12);

        drive(4'hF, 5);
        @(posedge clk);
        #1;
        rst_n       = 1'b0;
        ifc.req_vld = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(4'h0, 20);
        check_val("cnt_after_reset", 32'(u_dut.cnt_q), 0);
        check_val("p_after_reset", 32'(u_dut.ptr_q), 0);
        check_val("sb_main_empty", sbq[0].size(), 0);
        check_val("sb_cap_empty", sbq[1].size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_pipe_rr_arbiter.md
SHIFT_PIPE_RR_ARBITER -- requirements
Module: shift_pipe_rr_arbiter

Interface
REQ-001 Parameter n_req, default 4: number of requesters, 2..16.
REQ-002 Parameter width, default 8: data width per transfer.
REQ-003 Parameter depth, default 8: pipeline stages from grant to output, at least 2.
REQ-004 Parameter max_inflight, default 8: cap on transfers inside the pipeline, 1..depth.
REQ-005 clk  input  1  single clock; all state on posedge clk.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 req_vld  input  n_req  per-requester valid.
REQ-008 req_data  input  n_req*width  packed data; requester i occupies bits [i*width +: width].
REQ-009 req_rdy  output  n_req  per-requester grant, one-hot or zero.
REQ-010 out_vld  output  1  pipeline output valid.
REQ-011 out_data  output  width  pipeline output data.
REQ-012 out_id  output  $clog2(n_req)  index of the requester that sourced out_data.

Function
REQ-013 Transfer from requester i SHALL occur in a cycle where req_vld[i] and req_rdy[i] are both 1.
REQ-014 req_rdy SHALL be combinational from req_vld, the priority pointer and the in-flight count; at most one bit SHALL be set.
REQ-015 req_rdy[i] SHALL be 0 whenever req_vld[i] is 0.
REQ-016 Round-robin: the grant goes to the first requester with req_vld set, searching from the pointer p upward modulo n_req.
REQ-017 After a grant to requester i, p SHALL become (i+1) mod n_req on the next clock edge; p SHALL hold in cycles with no grant.
REQ-018 The internal pipeline SHALL have depth stages, each holding {vld, id, data}; all stages advance every cycle with no stall.
REQ-019 Stage 0 SHALL load {1, i, data_i} on a grant to i; otherwise it loads vld=0, and id/data hold their previous values.
REQ-020 Latency: a transfer accepted at edge t SHALL appear on out_vld/out_data/out_id in the cycle after edge t+depth-1, i.e. exactly depth cycles later.
REQ-021 out_* SHALL be driven directly from the last stage, with no combinational path from req_*.
REQ-022 The in-flight counter SHALL be $clog2(depth+1) bits wide: +1 on grant, -1 on out_vld, unchanged when both occur in the same cycle.
REQ-023 When the counter equals max_inflight and out_vld is 0, req_rdy SHALL be all-zero; when out_vld is 1 in that cycle, one grant is allowed.
REQ-024 The counter SHALL never exceed max_inflight nor underflow; bubbles SHALL not change it.
REQ-025 Transfer order at the output SHALL equal grant order; no transfer is dropped or duplicated.

Reset
REQ-026 While rst_n is 0: all stage vld bits, p and the counter SHALL be 0, and all stage id/data SHALL be 0.
REQ-027 During reset and in the first cycle after release: out_vld=0, out_data=0, out_id=0, req_rdy=0 while rst_n is 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight transfers immediately; none may appear after release.

Configuration
REQ-029 Macro SHIFT_PIPE_ARB_PRIO0_EN: when defined, requester 0 SHALL win whenever req_vld[0]=1 and a grant is allowed; otherwise round-robin as in REQ-016. Its grants SHALL update p per REQ-017.
REQ-030 Without SHIFT_PIPE_ARB_PRIO0_EN, the block SHALL be pure round-robin, and no extra logic for requester 0 is present.

Verification (n_req=4, width=8, depth=8, max_inflight=8 unless stated)
REQ-031 Reset then all req_vld=1 with data 8'hA0..8'hA3 -> grants 0,1,2,3,0,..., one per cycle; out_vld first rises 8 cycles after the first grant with out_id=0, out_data=8'hA0.
REQ-032 Only requester 2 valid with data 8'h5C for one cycle -> req_rdy=4'b0100 that cycle; 8 cycles later out_vld=1, out_id=2, out_data=8'h5C for exactly 1 cycle; p=3.
REQ-033 max_inflight=3 with all requesters continuously valid -> exactly 3 grants, then req_rdy=0 until the first out_vld; thereafter 3 transfers are in flight steady-state, and the counter is never above 3.
REQ-034 Assert rst_n=0 with 5 transfers in flight, release 2 cycles later -> out_vld stays 0 for 20 cycles; the counter and p are 0.
REQ-035 p=3, req_vld=4'b0011 -> grant to 0 (wrap-around); next cycle grant to 1.
REQ-036 With SHIFT_PIPE_ARB_PRIO0_EN, req_vld=4'b1111 held -> requester 0 is granted every cycle; without the macro -> rotation 0,1,2,3.
